// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared constants, FSM state type,
// read-token bundle and byte-merge helper for the L1 data array.
package l1_cache_pkg;

  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 8;
  localparam int NUM_WMASKS = DATA_W / 8;
  localparam int RSP_DEPTH  = 2;
  localparam int RAM_DEPTH  = 1 << ADDR_W;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  byp_valid;
    logic [DATA_W-1:0]     byp_data;
    logic [NUM_WMASKS-1:0] byp_mask;
  } rd_token_t;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]     old_d,
    input logic [DATA_W-1:0]     new_d,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [DATA_W-1:0] r;
    r = old_d;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (mask[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/l1_data_array_ctrl_if.sv
// l1_data_array_ctrl_if: write/read request and read response
// handshakes; master = cache pipeline, slave = array controller.
interface l1_data_array_ctrl_if;
  import l1_cache_pkg::*;

  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDR_W-1:0]     wr_req_addr;
  logic [DATA_W-1:0]     wr_req_data;
  logic [NUM_WMASKS-1:0] wr_req_mask;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_W-1:0]     rd_req_addr;

  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [DATA_W-1:0]     rd_rsp_data;

  modport master (
    output wr_req_valid, wr_req_addr,
    output wr_req_data, wr_req_mask,
    output rd_req_valid, rd_req_addr,
    output rd_rsp_ready,
    input  wr_req_ready, rd_req_ready,
    input  rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  wr_req_valid, wr_req_addr,
    input  wr_req_data, wr_req_mask,
    input  rd_req_valid, rd_req_addr,
    input  rd_rsp_ready,
    output wr_req_ready, rd_req_ready,
    output rd_rsp_valid, rd_rsp_data
  );

endinterface

// File: rtl/l1_rsp_fifo.sv
// l1_rsp_fifo: DEPTH x W synchronous FIFO with count/full/empty.
// Ports: push/din, pop/dout (head), count, full, empty.
module l1_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 128,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dout  = mem[rp];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/l1_data_array_ctrl.sv
// l1_data_array_ctrl: 1R1W SRAM front end with zero-fill, read queue
// and same-cycle write->read bypass. Ports: clk, rst_n, bus (slave),
// init_done, SRAM port 0 (csb0/addr0/din0/wmask0), port 1 (csb1/addr1/dout1).
module l1_data_array_ctrl
  import l1_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  l1_data_array_ctrl_if.slave   bus,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic [ADDR_W-1:0]     sram_addr0,
  output logic [DATA_W-1:0]     sram_din0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic                  sram_csb1,
  output logic [ADDR_W-1:0]     sram_addr1,
  input  logic [DATA_W-1:0]     sram_dout1
);

  localparam logic [0:0] S_INIT = 1'(INIT);
  localparam logic [0:0] S_RUN  = 1'(RUN);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] cnt_q;
  rd_token_t         tok_q, tok_d;

  logic              run;
  logic              wr_fire, rd_fire;
  logic              push, pop;
  logic [CW-1:0]     q_count;
  logic              q_full, q_empty;
  logic [DATA_W-1:0] q_head, cap_data;
  logic [OW-1:0]     occ;

  assign run       = state_q == S_RUN;
  assign init_done = run;

  assign bus.wr_req_ready = run;
  assign wr_fire = run & bus.wr_req_valid;

  assign pop = bus.rd_rsp_ready & ~q_empty;

  // Reservation covers queued + in-flight reads; a pop this
  // cycle frees its slot so reads stream at one per cycle.
  assign occ = OW'(q_count)
             + OW'(tok_q.valid)
             - OW'(pop);

  assign bus.rd_req_ready = run & (occ < OW'(RSP_DEPTH));
  assign rd_fire = bus.rd_req_valid & bus.rd_req_ready;

  always_comb begin
    sram_csb0   = ~bus.wr_req_valid;
    sram_addr0  = bus.wr_req_addr;
    sram_din0   = bus.wr_req_data;
    sram_wmask0 = bus.wr_req_mask;
    if (!run) begin
      // Sweep writes zeros; held off while reset is asserted.
      sram_csb0   = ~rst_n;
      sram_addr0  = cnt_q;
      sram_din0   = '0;
      sram_wmask0 = '1;
    end
  end

  assign sram_csb1  = ~rd_fire;
  assign sram_addr1 = bus.rd_req_addr;

  // Macro result is undefined on a same-address collision,
  // so the write's bytes ride along with the read token.
  always_comb begin
    tok_d           = '0;
    tok_d.valid     = rd_fire;
    tok_d.byp_valid = rd_fire & wr_fire
                    & (bus.wr_req_addr == bus.rd_req_addr);
    tok_d.byp_data  = bus.wr_req_data;
    tok_d.byp_mask  = bus.wr_req_mask;
  end

  assign cap_data = tok_q.byp_valid
                  ? merge_bytes(sram_dout1, tok_q.byp_data,
                                tok_q.byp_mask)
                  : sram_dout1;

  assign push = tok_q.valid & (~q_full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      tok_q   <= '0;
    end else begin
      tok_q <= tok_d;
      if (!run) begin
        cnt_q <= cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(RAM_DEPTH - 1)) begin
          state_q <= S_RUN;
        end
      end
    end
  end

  l1_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DATA_W),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cap_data),
    .pop   (pop),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.rd_rsp_valid = ~q_empty;
  assign bus.rd_rsp_data  = q_head;

endmodule
